// File: rtl/udp_table_reader.sv
// Scans all 16 rows of a 4-input function and captures its response into a truth table.
// Latency: done pulses 16*(SETTLE+1)+1 cycles after start is accepted; each row is held SETTLE+1 cycles.
// Backpressure: none; start is sampled only in IDLE, and a start seen while scanning or finishing is dropped.
// Optional compare port set enabled by defining UDP_TABLE_CMP_EN.
module udp_table_reader #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        E,
`ifdef UDP_TABLE_CMP_EN
    input  logic [15:0] expected,
    output logic        mismatch,
`endif
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [3:0]  index
);

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state, state_nxt;
    logic [3:0]  index_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] truth_nxt;
    logic        sample;

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        cnt_nxt   = cnt;
        truth_nxt = truth;
        sample    = (state == DRIVE) && (cnt == SETTLE_CNT);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    index_nxt = 4'd0;
                    cnt_nxt   = 4'd0;
                    truth_nxt = 16'h0000;
                end
            end
            DRIVE: begin
                if (sample) begin
                    truth_nxt[index] = E;
                    cnt_nxt          = 4'd0;
                    // Last row leaves index at 15 so the stimulus never wraps mid-scan.
                    if (index == 4'd15)
                        state_nxt = FINISH;
                    else
                        index_nxt = index + 4'd1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= 4'd0;
            cnt   <= 4'd0;
            truth <= 16'h0000;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
            cnt   <= cnt_nxt;
            truth <= truth_nxt;
        end
    end

`ifdef UDP_TABLE_CMP_EN
    // Compare against the final table on the entry edge so the flag is valid during FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mismatch <= 1'b0;
        else if (state == IDLE && start)
            mismatch <= 1'b0;
        else if (sample && index == 4'd15)
            mismatch <= (truth_nxt != expected);
    end
`endif

    assign {A, B, C, D} = index;
    assign busy         = (state == DRIVE);
    assign done         = (state == FINISH);

endmodule

// File: tb/tb_udp_table_reader.sv
// Directed bench for udp_table_reader: SETTLE=2 and SETTLE=0 instances against hand-computed tables.
module tb_udp_table_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start2, start0;
    int          mode2, mode0;
    logic        a2, b2, c2, d2, e2, busy2, done2;
    logic        a0, b0, c0, d0, e0, busy0, done0;
    logic [15:0] truth2, truth0;
    logic [3:0]  index2, index0;
    logic        mismatch2, mismatch0;
`ifdef UDP_TABLE_CMP_EN
    logic [15:0] expected2, expected0;
`else
    assign mismatch2 = 1'b0;
    assign mismatch0 = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic efn(input int m, input logic a, input logic b, input logic c, input logic d);
        case (m)
            1:       return a & b & c & d;
            2:       return d;
            3:       return a;
            4:       return b ^ c;
            default: return 1'b0;
        endcase
    endfunction

    assign e2 = efn(mode2, a2, b2, c2, d2);
    assign e0 = efn(mode0, a0, b0, c0, d0);

    udp_table_reader #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .E(e2),
`ifdef UDP_TABLE_CMP_EN
        .expected(expected2), .mismatch(mismatch2),
`endif
        .A(a2), .B(b2), .C(c2), .D(d2), .busy(busy2), .done(done2),
        .truth(truth2), .index(index2)
    );

    udp_table_reader #(.SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .E(e0),
`ifdef UDP_TABLE_CMP_EN
        .expected(expected0), .mismatch(mismatch0),
`endif
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0),
        .truth(truth0), .index(index0)
    );

    // Starts one scan and observes 60 cycles; cycle 1 is the first sample after the accepting edge.
    task automatic do_scan(input int sel, input int pulse_at,
                           output int done_cyc, output int busy_cyc,
                           output bit shape_ok, output bit unsampled_ok,
                           output logic [15:0] t_done, output logic mm);
        logic       bs, dn;
        logic [3:0] abcd, idx;
        logic [15:0] t;
        done_cyc = 0; busy_cyc = 0; shape_ok = 1'b1; unsampled_ok = 1'b1; t_done = '0; mm = 1'b0;
        @(negedge clk);
        if (sel != 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start2 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            bs   = (sel != 0) ? busy0 : busy2;
            dn   = (sel != 0) ? done0 : done2;
            abcd = (sel != 0) ? {a0, b0, c0, d0} : {a2, b2, c2, d2};
            idx  = (sel != 0) ? index0 : index2;
            t    = (sel != 0) ? truth0 : truth2;
            if (bs) begin
                busy_cyc++;
                if (abcd != idx) shape_ok = 1'b0;
                if ((t & (16'hFFFF << idx)) != 16'h0000) unsampled_ok = 1'b0;
            end
            if (dn) begin
                if (done_cyc == 0) begin
                    done_cyc = n;
                    t_done   = t;
                    mm       = (sel != 0) ? mismatch0 : mismatch2;
                end else begin
                    shape_ok = 1'b0;
                end
            end
            if (n == pulse_at) begin
                if (sel != 0) start0 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start2 = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [25:0] v;
        rst_n = 1'b0;
        #12;
        v = {a2, b2, c2, d2, busy2, done2, index2, truth2, mismatch2};
        n_chk++;
        if (v !== 26'd0) begin n_fail++; $display("FAIL reset_s2 got %h want 0", v); end
        v = {a0, b0, c0, d0, busy0, done0, index0, truth0, mismatch0};
        n_chk++;
        if (v !== 26'd0) begin n_fail++; $display("FAIL reset_s0 got %h want 0", v); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy2, busy0, done2, done0} !== 4'b0000) begin
            n_fail++; $display("FAIL idle_no_start got %b want 0000", {busy2, busy0, done2, done0});
        end
    endtask

    task automatic test_zero;
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        mode2 = 0;
        do_scan(0, 0, dc, bc, sok, uok, t, mm);
        n_chk++; if (dc != 49) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 49", dc); end
        n_chk++; if (bc != 48) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 48", bc); end
        n_chk++; if (t !== 16'h0000) begin n_fail++; $display("FAIL zero_truth got %h want 0000", t); end
        n_chk++; if (!sok) begin n_fail++; $display("FAIL zero_abcd_index got 0 want 1"); end
    endtask

    task automatic test_patterns;
        int          modes [3] = '{1, 2, 3};
        logic [15:0] exps  [3] = '{16'h8000, 16'hAAAA, 16'hFF00};
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        for (int i = 0; i < 3; i++) begin
            mode2 = modes[i];
            do_scan(0, 0, dc, bc, sok, uok, t, mm);
            n_chk++;
            if (t !== exps[i]) begin n_fail++; $display("FAIL pattern%0d_truth got %h want %h", modes[i], t, exps[i]); end
            n_chk++;
            if (!(sok && uok && dc == 49)) begin
                n_fail++; $display("FAIL pattern%0d_shape got ok=%0d unsampled=%0d done=%0d want 1 1 49", modes[i], sok, uok, dc);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_chk++;
        if (truth2 !== 16'hFF00) begin n_fail++; $display("FAIL truth_hold got %h want ff00", truth2); end
    endtask

    task automatic test_settle0;
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        mode0 = 4;
        do_scan(1, 0, dc, bc, sok, uok, t, mm);
        n_chk++; if (t !== 16'h3C3C) begin n_fail++; $display("FAIL s0_truth got %h want 3c3c", t); end
        n_chk++; if (dc != 17) begin n_fail++; $display("FAIL s0_done_cycle got %0d want 17", dc); end
        n_chk++; if (bc != 16) begin n_fail++; $display("FAIL s0_busy_cycles got %0d want 16", bc); end
        n_chk++; if (!(sok && uok)) begin n_fail++; $display("FAIL s0_shape got %0d%0d want 11", sok, uok); end
    endtask

    task automatic test_start_ignored;
        int pulses [2] = '{10, 49};
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        mode2 = 3;
        for (int i = 0; i < 2; i++) begin
            do_scan(0, pulses[i], dc, bc, sok, uok, t, mm);
            n_chk++;
            if (dc != 49 || bc != 48) begin
                n_fail++; $display("FAIL ignore_at_%0d got done=%0d busy=%0d want 49 48", pulses[i], dc, bc);
            end
            n_chk++;
            if (t !== 16'hFF00 || !sok) begin
                n_fail++; $display("FAIL ignore_at_%0d_truth got %h ok=%0d want ff00 1", pulses[i], t, sok);
            end
        end
    endtask

    task automatic test_reset_mid;
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        bit reached = 1'b0;
        bit activity = 1'b0;
        logic [25:0] v;
        mode2 = 3;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            if (index2 == 4'd7) reached = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_chk++;
        if (!reached) begin n_fail++; $display("FAIL mid_reach_index7 got %0d want 7", index2); end
        #2 rst_n = 1'b0;
        #1;
        v = {a2, b2, c2, d2, busy2, done2, index2, truth2, mismatch2};
        n_chk++;
        if (v !== 26'd0) begin n_fail++; $display("FAIL mid_reset_outputs got %h want 0", v); end
        @(negedge clk); rst_n = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (busy2 || done2) activity = 1'b1;
        end
        n_chk++;
        if (activity) begin n_fail++; $display("FAIL mid_no_resume got activity=1 want 0"); end
        do_scan(0, 0, dc, bc, sok, uok, t, mm);
        n_chk++;
        if (t !== 16'hFF00 || dc != 49) begin n_fail++; $display("FAIL mid_rescan got %h done=%0d want ff00 49", t, dc); end
    endtask

`ifdef UDP_TABLE_CMP_EN
    task automatic test_cmp;
        int dc, bc; bit sok, uok; logic [15:0] t; logic mm;
        mode2 = 3;
        expected2 = 16'h0000;
        do_scan(0, 0, dc, bc, sok, uok, t, mm);
        n_chk++; if (mm !== 1'b1) begin n_fail++; $display("FAIL cmp_mismatch got %b want 1", mm); end
        expected2 = 16'hFF00;
        do_scan(0, 0, dc, bc, sok, uok, t, mm);
        n_chk++; if (mm !== 1'b0) begin n_fail++; $display("FAIL cmp_match got %b want 0", mm); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0; mode2 = 0; mode0 = 0;
`ifdef UDP_TABLE_CMP_EN
        expected2 = 16'h0000; expected0 = 16'h0000;
`endif
        test_reset;
        test_zero;
        test_patterns;
        test_settle0;
        test_start_ignored;
        test_reset_mid;
`ifdef UDP_TABLE_CMP_EN
        test_cmp;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
